// File: rtl/ff_bank_pkg.sv
// Shared types and helpers for the ff_bank flip-flop bank.
// Channel mode encoding, the forbidden SR input pair and a popcount helper.
package ff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    localparam logic [1:0] SR_ILLEGAL = 2'b11;
    localparam int         POP_W      = 6;

    // Counts set bits of a channel mask; CH is at most 32, so 6 bits suffice.
    function automatic logic [POP_W-1:0] popcount32(input logic [31:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'b00000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ff_bank_cell.sv
// One flip-flop channel: mode-dependent next-state mux and the q register.
// illegal_evt_o is a same-cycle pulse for an enabled SR channel seeing S=R=1.
module ff_cell
    import ff_bank_pkg::*;
#(
    parameter bit RST_Q = 1'b0
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  en_i,
    input  mode_e mode_i,
    input  logic  a_i,
    input  logic  b_i,
    output logic  q_o,
    output logic  illegal_evt_o
);

    logic q_q;
    logic q_d;
    logic evt_s;

    // Next-state selection; a disabled channel holds and never reports an event.
    always_comb begin
        q_d   = q_q;
        evt_s = 1'b0;
        if (en_i) begin
            case (mode_i)
                MODE_SR: begin
                    case ({a_i, b_i})
                        2'b01:      q_d = 1'b0;
                        2'b10:      q_d = 1'b1;
                        SR_ILLEGAL: evt_s = 1'b1;
                        default:    q_d = q_q;
                    endcase
                end
                MODE_JK: begin
                    case ({a_i, b_i})
                        2'b01:   q_d = 1'b0;
                        2'b10:   q_d = 1'b1;
                        2'b11:   q_d = ~q_q;
                        default: q_d = q_q;
                    endcase
                end
                MODE_D:  q_d = a_i;
                MODE_T:  q_d = a_i ? ~q_q : q_q;
                default: q_d = q_q;
            endcase
        end else begin
            q_d   = q_q;
            evt_s = 1'b0;
        end
    end

    // Channel state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= RST_Q;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o           = q_q;
    assign illegal_evt_o = evt_s;

endmodule

// File: rtl/ff_bank.sv
// Bank of CH runtime-configurable SR/JK/D/T flip-flops with sticky
// per-channel illegal-input flags and a saturating illegal-event counter.
module ff_bank
    import ff_bank_pkg::*;
#(
    parameter int CH    = 4,
    parameter int CNT_W = 8,
    parameter bit RST_Q = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cfg_we,
    input  logic [(CH > 1 ? $clog2(CH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                           cfg_mode,
    input  logic [CH-1:0]                        en,
    input  logic [CH-1:0]                        a,
    input  logic [CH-1:0]                        b,
    input  logic                                 err_clr,
    output logic [CH-1:0]                        q,
    output logic [CH-1:0]                        qb,
    output logic [2*CH-1:0]                      mode_o,
    output logic [CH-1:0]                        illegal,
    output logic [CNT_W-1:0]                     illegal_cnt
);

    localparam int SW = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

    mode_e             mode_q [CH];
    logic [CH-1:0]     q_s;
    logic [CH-1:0]     evt_s;
    logic [CH-1:0]     illegal_q;
    logic [CH-1:0]     illegal_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cnt_base_s;
    logic [POP_W-1:0]  pop_s;
    logic [SW-1:0]     sum_s;

    // Mode registers; an out-of-range cfg_ch matches no channel and is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                mode_q[i] <= MODE_SR;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (cfg_we && (32'(cfg_ch) == i)) begin
                    mode_q[i] <= mode_e'(cfg_mode);
                end else begin
                    mode_q[i] <= mode_q[i];
                end
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_cell
        ff_cell #(
            .RST_Q (RST_Q)
        ) u_cell (
            .clk_i         (clk),
            .rst_i         (rst),
            .en_i          (en[g]),
            .mode_i        (mode_q[g]),
            .a_i           (a[g]),
            .b_i           (b[g]),
            .q_o           (q_s[g]),
            .illegal_evt_o (evt_s[g])
        );
    end

    // Clear is applied before this cycle's events, so a colliding event survives.
    always_comb begin
        if (err_clr) begin
            illegal_d  = evt_s;
            cnt_base_s = '0;
        end else begin
            illegal_d  = illegal_q | evt_s;
            cnt_base_s = cnt_q;
        end
        pop_s = popcount32(32'(evt_s));
        sum_s = SW'(cnt_base_s) + SW'(pop_s);
        if (sum_s > CNT_MAX) begin
            cnt_d = CNT_MAX[CNT_W-1:0];
        end else begin
            cnt_d = sum_s[CNT_W-1:0];
        end
    end

    // Sticky flags and saturating counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= '0;
            cnt_q     <= '0;
        end else begin
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // Pack per-channel modes into the flat status bus.
    always_comb begin
        mode_o = '0;
        for (int i = 0; i < CH; i++) begin
            mode_o[2*i +: 2] = mode_q[i];
        end
    end

    assign q           = q_s;
    assign qb          = ~q_s;
    assign illegal     = illegal_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_ff_bank.sv
// Directed, table-driven bench for ff_bank: a CH=4/CNT_W=3 instance for the
// main behaviour and a CH=5/RST_Q=1 instance for reset value and bad config.
module tb_ff_bank;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: CH=4, CNT_W=3, RST_Q=0
    logic       cfg_we0 = 1'b0;
    logic [1:0] cfg_ch0 = 2'd0;
    logic [1:0] cfg_md0 = 2'd0;
    logic [3:0] en0 = 4'd0, a0 = 4'd0, b0 = 4'd0;
    logic       clr0 = 1'b0;
    logic [3:0] q0, qb0, ill0;
    logic [7:0] mode0;
    logic [2:0] cnt0;

    // Instance 1: CH=5, CNT_W=8, RST_Q=1
    logic       cfg_we1 = 1'b0;
    logic [2:0] cfg_ch1 = 3'd0;
    logic [1:0] cfg_md1 = 2'd0;
    logic [4:0] en1 = 5'd0, a1 = 5'd0, b1 = 5'd0;
    logic       clr1 = 1'b0;
    logic [4:0] q1, qb1, ill1;
    logic [9:0] mode1;
    logic [7:0] cnt1;

    ff_bank #(.CH(4), .CNT_W(3), .RST_Q(1'b0)) dut0 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we0), .cfg_ch(cfg_ch0), .cfg_mode(cfg_md0),
        .en(en0), .a(a0), .b(b0), .err_clr(clr0),
        .q(q0), .qb(qb0), .mode_o(mode0), .illegal(ill0), .illegal_cnt(cnt0)
    );

    ff_bank #(.CH(5), .CNT_W(8), .RST_Q(1'b1)) dut1 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we1), .cfg_ch(cfg_ch1), .cfg_mode(cfg_md1),
        .en(en1), .a(a1), .b(b1), .err_clr(clr1),
        .q(q1), .qb(qb1), .mode_o(mode1), .illegal(ill1), .illegal_cnt(cnt1)
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // qb must be the exact complement of q on every cycle once reset has been seen.
    always @(negedge clk) begin
        if (armed) begin
            chk("qb0_comp", {28'd0, qb0}, {28'd0, ~q0});
            chk("qb1_comp", {27'd0, qb1}, {27'd0, ~q1});
        end
    end

    typedef struct {
        logic       we;
        logic [1:0] ch;
        logic [1:0] md;
        logic [3:0] en;
        logic [3:0] a;
        logic [3:0] b;
        logic       clr;
        logic [3:0] q;
        logic [7:0] mode;
        logic [3:0] ill;
        logic [2:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] ch, input logic [1:0] md,
                                input logic [3:0] en, input logic [3:0] a, input logic [3:0] b,
                                input logic clr, input logic [3:0] q, input logic [7:0] mode,
                                input logic [3:0] ill, input logic [2:0] cnt);
        vec_t v;
        v.we = we; v.ch = ch; v.md = md; v.en = en; v.a = a; v.b = b; v.clr = clr;
        v.q = q; v.mode = mode; v.ill = ill; v.cnt = cnt;
        return v;
    endfunction

    vec_t vecs [20];

    initial begin
        //              we    ch     md     en       a        b        clr   q        mode   ill      cnt
        vecs[0]  = mk(1'b0, 2'd0, 2'd0, 4'b0001, 4'b1111, 4'b1110, 1'b0, 4'b0001, 8'h00, 4'b0000, 3'd0);
        vecs[1]  = mk(1'b0, 2'd0, 2'd0, 4'b0001, 4'b1110, 4'b1110, 1'b0, 4'b0001, 8'h00, 4'b0000, 3'd0);
        vecs[2]  = mk(1'b0, 2'd0, 2'd0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 4'b0000, 8'h00, 4'b0000, 3'd0);
        vecs[3]  = mk(1'b0, 2'd0, 2'd0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0000, 8'h00, 4'b0001, 3'd1);
        // Mode writes: data on the write edge still follows the old SR mode
        vecs[4]  = mk(1'b1, 2'd1, 2'd1, 4'b1111, 4'b0010, 4'b0000, 1'b0, 4'b0010, 8'h04, 4'b0001, 3'd1);
        vecs[5]  = mk(1'b1, 2'd2, 2'd2, 4'b1111, 4'b0100, 4'b0100, 1'b0, 4'b0010, 8'h24, 4'b0101, 3'd2);
        vecs[6]  = mk(1'b1, 2'd3, 2'd3, 4'b1111, 4'b1000, 4'b0000, 1'b0, 4'b1010, 8'hE4, 4'b0101, 3'd2);
        vecs[7]  = mk(1'b0, 2'd0, 2'd0, 4'b1111, 4'b1110, 4'b0010, 1'b0, 4'b0100, 8'hE4, 4'b0101, 3'd2);
        vecs[8]  = mk(1'b0, 2'd0, 2'd0, 4'b1111, 4'b1110, 4'b0010, 1'b0, 4'b1110, 8'hE4, 4'b0101, 3'd2);
        vecs[9]  = mk(1'b0, 2'd0, 2'd0, 4'b1111, 4'b0010, 4'b0010, 1'b0, 4'b1000, 8'hE4, 4'b0101, 3'd2);
        vecs[10] = mk(1'b0, 2'd0, 2'd0, 4'b0110, 4'b1111, 4'b1111, 1'b0, 4'b1110, 8'hE4, 4'b0101, 3'd2);
        // Mode changes alone never touch q
        vecs[11] = mk(1'b1, 2'd3, 2'd0, 4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b1110, 8'h24, 4'b0101, 3'd2);
        vecs[12] = mk(1'b1, 2'd2, 2'd0, 4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b1110, 8'h04, 4'b0101, 3'd2);
        vecs[13] = mk(1'b1, 2'd1, 2'd0, 4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b1110, 8'h00, 4'b0101, 3'd2);
        // Saturation at 7 with CNT_W=3, then clears
        vecs[14] = mk(1'b0, 2'd0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b1110, 8'h00, 4'b0000, 3'd0);
        vecs[15] = mk(1'b0, 2'd0, 2'd0, 4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b1110, 8'h00, 4'b1111, 3'd4);
        vecs[16] = mk(1'b0, 2'd0, 2'd0, 4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b1110, 8'h00, 4'b1111, 3'd7);
        vecs[17] = mk(1'b0, 2'd0, 2'd0, 4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b1110, 8'h00, 4'b1111, 3'd7);
        vecs[18] = mk(1'b0, 2'd0, 2'd0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 4'b1110, 8'h00, 4'b0000, 3'd0);
        // Clear colliding with events on ch0 and ch2
        vecs[19] = mk(1'b0, 2'd0, 2'd0, 4'b0101, 4'b1111, 4'b1111, 1'b1, 4'b1110, 8'h00, 4'b0101, 3'd2);

        // Reset pulse in the middle of a clock period
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_q0",    {28'd0, q0},   32'h0);
        chk("rst_qb0",   {28'd0, qb0},  32'hF);
        chk("rst_mode0", {24'd0, mode0}, 32'h0);
        chk("rst_ill0",  {28'd0, ill0}, 32'h0);
        chk("rst_cnt0",  {29'd0, cnt0}, 32'h0);
        chk("rst_q1",    {27'd0, q1},   32'h1F);
        chk("rst_qb1",   {27'd0, qb1},  32'h0);
        armed = 1'b1;
        #1 rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            cfg_we0 = vecs[i].we;
            cfg_ch0 = vecs[i].ch;
            cfg_md0 = vecs[i].md;
            en0     = vecs[i].en;
            a0      = vecs[i].a;
            b0      = vecs[i].b;
            clr0    = vecs[i].clr;
            step();
            chk($sformatf("v%0d_q", i),    {28'd0, q0},    {28'd0, vecs[i].q});
            chk($sformatf("v%0d_qb", i),   {28'd0, qb0},   {28'd0, ~vecs[i].q});
            chk($sformatf("v%0d_mode", i), {24'd0, mode0}, {24'd0, vecs[i].mode});
            chk($sformatf("v%0d_ill", i),  {28'd0, ill0},  {28'd0, vecs[i].ill});
            chk($sformatf("v%0d_cnt", i),  {29'd0, cnt0},  {29'd0, vecs[i].cnt});
        end
        cfg_we0 = 1'b0;
        clr0    = 1'b0;
        en0     = 4'b0000;

        // Instance 1: out-of-range writes are dropped, in-range write lands
        chk("d1_q_hold", {27'd0, q1}, 32'h1F);
        cfg_we1 = 1'b1; cfg_ch1 = 3'd5; cfg_md1 = 2'b11;
        step();
        chk("d1_bad5", {22'd0, mode1}, 32'h0);
        cfg_ch1 = 3'd4; cfg_md1 = 2'b10;
        step();
        chk("d1_good4", {22'd0, mode1}, 32'h200);
        cfg_ch1 = 3'd7; cfg_md1 = 2'b01;
        step();
        chk("d1_bad7", {22'd0, mode1}, 32'h200);
        cfg_we1 = 1'b0; en1 = 5'b10000; a1 = 5'b00000; b1 = 5'b11111;
        step();
        chk("d1_dmode", {27'd0, q1}, 32'h0F);
        chk("d1_noill", {27'd0, ill1}, 32'h0);
        en1 = 5'b00000;

        // Mid-period reset overriding a pending config write and data update
        cfg_we0 = 1'b1; cfg_ch0 = 2'd1; cfg_md0 = 2'b01;
        en0 = 4'b1111; a0 = 4'b1111; b0 = 4'b0000;
        #3 rst = 1'b1;
        #1;
        chk("mid_q0",    {28'd0, q0},    32'h0);
        chk("mid_qb0",   {28'd0, qb0},   32'hF);
        chk("mid_mode0", {24'd0, mode0}, 32'h0);
        chk("mid_ill0",  {28'd0, ill0},  32'h0);
        chk("mid_cnt0",  {29'd0, cnt0},  32'h0);
        chk("mid_mode1", {22'd0, mode1}, 32'h0);
        chk("mid_q1",    {27'd0, q1},    32'h1F);
        step();
        chk("held_q0",    {28'd0, q0},    32'h0);
        chk("held_mode0", {24'd0, mode0}, 32'h0);
        cfg_we0 = 1'b0; en0 = 4'b0000;
        #3 rst = 1'b0;
        step();
        chk("post_mode0", {24'd0, mode0}, 32'h0);
        chk("post_q0",    {28'd0, q0},    32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
